uart_tx_scheduler: RTL and testbench
====================================

# uart_tx_scheduler

Sequencing controller in front of the UART transmitter. It arbitrates between two response sources, the register-file read path (1 byte) and the ALU result path (2 bytes), and serialises their bytes into the UART TX frame engine one frame at a time. It handles the D_Valid/busy handshake, the retry on a lost start, and multi-byte ordering. It sits between the system controller datapath and UART_TX in the UART clock domain.

## Interface
- `TIMEOUT`, default 4: cycles to wait for `tx_busy` to rise after a `tx_d_valid` pulse before re-issuing the byte (≥2).
- `clk` input 1: system/UART clock, rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `rf_req` input 1: register-file byte ready (level).
- `rf_data` input 8: register-file byte, valid while `rf_req`=1.
- `rf_ack` output 1: one-cycle pulse when `rf_data` has been captured.
- `alu_req` input 1: ALU result ready (level).
- `alu_data` input 16: ALU result, valid while `alu_req`=1.
- `alu_ack` output 1: one-cycle pulse when `alu_data` has been captured.
- `tx_busy` input 1: UART TX busy (high from start bit through stop bit).
- `tx_p_data` output 8: byte presented to UART TX.
- `tx_d_valid` output 1: one-cycle start pulse to UART TX.
- `sched_busy` output 1: high whenever the state is not IDLE.

## Operation
- All outputs are registered. Reset values: `rf_ack`=0, `alu_ack`=0, `tx_d_valid`=0, `tx_p_data`=8'h00, `sched_busy`=0. Internal reset: state=IDLE, `hold`=16'h0000, `bytes_left`=0, `timer`=0, `rr_last`=ALU, so RF wins the first tie.
- States:
  - IDLE: with no request, remain in IDLE.
    - Exactly one request: grant it.
    - Both requests: grant the requester other than `rr_last`.
    - On grant: capture data into `hold`, set `bytes_left` (RF=1, ALU=2), pulse the matching ack, update `rr_last`, go to LOAD.
  - LOAD:
    - `tx_busy`=1: stay in LOAD and issue nothing.
    - `tx_busy`=0: drive `tx_p_data`=`hold[7:0]`, pulse `tx_d_valid`, clear `timer`, go to WAIT_HI.
  - WAIT_HI:
    - `tx_busy`=1: go to WAIT_LO.
    - Otherwise increment `timer`. When `timer`=`TIMEOUT`-1, return to LOAD and re-issue the same byte.
  - WAIT_LO: wait for `tx_busy`=0.
    - `bytes_left`=2: set `hold`={8'h00, `hold[15:8]`} and `bytes_left`=1, go to LOAD.
    - `bytes_left`=1: set `bytes_left`=0, go to IDLE.
- Byte order for ALU results: low byte `alu_data[7:0]` first, then `alu_data[15:8]`.
- Requesters must drop `req` on the cycle after the ack. A `req` still high when the scheduler next reaches IDLE counts as a new request.
- Requests arriving while not in IDLE are ignored until IDLE. There is no queueing beyond `hold`.
- Asserting reset mid-frame returns to IDLE immediately and drops the in-flight bytes. Any partially sent UART frame is the UART's concern.

## Timing
- Grant latency: `req` high in IDLE at edge N → ack=1 and state=LOAD after edge N+1 → ack=0 after edge N+2.
- With `tx_busy`=0, `tx_d_valid`=1 and `tx_p_data` valid after edge N+2, and `tx_d_valid`=0 after edge N+3.
- `tx_p_data` is held stable from the `tx_d_valid` pulse until the next LOAD issue.
- UART TX raises busy one cycle after the pulse, so WAIT_HI normally exits after one cycle.
- Between bytes, the next `tx_d_valid` comes 2 cycles after `tx_busy` falls: one edge WAIT_LO→LOAD, one edge LOAD→issue.
- After the last byte, the scheduler returns to IDLE 1 cycle after `tx_busy` falls. The next grant follows in the same IDLE cycle evaluation.
- Worst-case retry: `TIMEOUT` cycles in WAIT_HI, then 1 cycle in LOAD, then a fresh pulse.

## Test plan
- RF single byte: `rf_req`=1, `rf_data`=8'hA5, `tx_busy` model idle → `rf_ack` pulses 1 cycle. One `tx_d_valid` pulse with `tx_p_data`=8'hA5. Once the model's busy falls, `sched_busy` clears.
- ALU two bytes: `alu_data`=16'h1234 → two `tx_d_valid` pulses with 8'h34 then 8'h12. The second pulse comes exactly 2 cycles after the first busy falls.
- Simultaneous requests: both `req` high after reset → RF served first (8'h5A). After it finishes, the ALU is served. A repeat tie then grants RF again, because round-robin alternates.
- Lost start: `tx_busy` held 0 after the pulse → `tx_d_valid` re-pulses with the same byte after `TIMEOUT`+1 cycles (5 at default). Releasing busy afterwards completes normally.
- Busy at entry: `tx_busy`=1 when LOAD is entered → no `tx_d_valid` until busy is 0, then exactly one pulse.
- Reset mid-operation: reset asserted in WAIT_LO of the ALU first byte → all outputs 0 and state IDLE immediately. After release, no second byte is sent.

Source files
------------

// File: rtl/uart_tx_scheduler.sv
// Arbitrates register-file (1 byte) and ALU (2 byte) responses and feeds their
// bytes one frame at a time into the UART TX engine, retrying lost starts.
module uart_tx_scheduler #(
    parameter int TIMEOUT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rf_req,
    input  logic [7:0]  rf_data,
    output logic        rf_ack,
    input  logic        alu_req,
    input  logic [15:0] alu_data,
    output logic        alu_ack,
    input  logic        tx_busy,
    output logic [7:0]  tx_p_data,
    output logic        tx_d_valid,
    output logic        sched_busy
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT_HI,
        WAIT_LO
    } state_t;

    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

    state_t      state;
    logic [15:0] hold;
    logic [1:0]  bytes_left;
    logic [7:0]  timer;
    logic        rr_last_alu;

    // rr_last_alu resets high so the register file wins the first tie.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            hold        <= 16'h0000;
            bytes_left  <= 2'd0;
            timer       <= 8'd0;
            rr_last_alu <= 1'b1;
            rf_ack      <= 1'b0;
            alu_ack     <= 1'b0;
            tx_d_valid  <= 1'b0;
            tx_p_data   <= 8'h00;
            sched_busy  <= 1'b0;
        end else begin
            rf_ack     <= 1'b0;
            alu_ack    <= 1'b0;
            tx_d_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (rf_req && (!alu_req || rr_last_alu)) begin
                        hold        <= {8'h00, rf_data};
                        bytes_left  <= 2'd1;
                        rf_ack      <= 1'b1;
                        rr_last_alu <= 1'b0;
                        state       <= LOAD;
                        sched_busy  <= 1'b1;
                    end else if (alu_req) begin
                        hold        <= alu_data;
                        bytes_left  <= 2'd2;
                        alu_ack     <= 1'b1;
                        rr_last_alu <= 1'b1;
                        state       <= LOAD;
                        sched_busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    if (!tx_busy) begin
                        tx_p_data  <= hold[7:0];
                        tx_d_valid <= 1'b1;
                        timer      <= 8'd0;
                        state      <= WAIT_HI;
                    end
                end
                // A start the UART never acknowledged is re-issued from LOAD.
                WAIT_HI: begin
                    if (tx_busy) begin
                        state <= WAIT_LO;
                    end else if (timer == TIMER_LAST) begin
                        state <= LOAD;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end
                WAIT_LO: begin
                    if (!tx_busy) begin
                        if (bytes_left == 2'd2) begin
                            hold       <= {8'h00, hold[15:8]};
                            bytes_left <= 2'd1;
                            state      <= LOAD;
                        end else begin
                            bytes_left <= 2'd0;
                            state      <= IDLE;
                            sched_busy <= 1'b0;
                        end
                    end
                end
                default: begin
                    state      <= IDLE;
                    sched_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: table of single transactions driven
// against a simple UART busy model, plus hand-written corner sequences.
module tb_uart_tx_scheduler;

    typedef struct {
        logic        rf_req;
        logic [7:0]  rf_data;
        logic        alu_req;
        logic [15:0] alu_data;
        logic        exp_rf_ack;
        logic        exp_alu_ack;
        int          exp_n;
        logic [7:0]  exp_b0;
        logic [7:0]  exp_b1;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rf_req = 1'b0;
    logic [7:0]  rf_data = 8'h00;
    logic        rf_ack;
    logic        alu_req = 1'b0;
    logic [15:0] alu_data = 16'h0000;
    logic        alu_ack;
    logic        tx_busy;
    logic [7:0]  tx_p_data;
    logic        tx_d_valid;
    logic        sched_busy;

    logic        model_en = 1'b0;
    logic        model_busy = 1'b0;
    logic        manual_busy = 1'b0;
    logic        prev_busy = 1'b0;
    int          busy_cnt = 0;
    int          cyc = 0;
    int          compared = 0;
    int          mismatched = 0;
    logic [7:0]  pulse_bytes[$];
    int          pulse_cyc[$];
    int          fall_cyc[$];
    vec_t        vecs[6];

    assign tx_busy = model_en ? model_busy : manual_busy;

    uart_tx_scheduler #(.TIMEOUT(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .rf_req     (rf_req),
        .rf_data    (rf_data),
        .rf_ack     (rf_ack),
        .alu_req    (alu_req),
        .alu_data   (alu_data),
        .alu_ack    (alu_ack),
        .tx_busy    (tx_busy),
        .tx_p_data  (tx_p_data),
        .tx_d_valid (tx_d_valid),
        .sched_busy (sched_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // UART model: busy rises the cycle after a start pulse and lasts 3 cycles.
    always @(posedge clk) begin
        #1;
        if (!model_en) begin
            busy_cnt   = 0;
            model_busy = 1'b0;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) model_busy = 1'b0;
        end else if (tx_d_valid) begin
            model_busy = 1'b1;
            busy_cnt   = 3;
        end
    end

    always @(negedge clk) begin
        if (tx_d_valid) begin
            pulse_bytes.push_back(tx_p_data);
            pulse_cyc.push_back(cyc);
        end
        if (prev_busy && !tx_busy) fall_cyc.push_back(cyc);
        prev_busy = tx_busy;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic clearLog();
        pulse_bytes.delete();
        pulse_cyc.delete();
        fall_cyc.delete();
    endtask

    task automatic waitAck();
        int n = 0;
        while (!(rf_ack || alu_ack) && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic waitIdle(input string name);
        int n = 0;
        while (sched_busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, {31'd0, sched_busy}, 32'd0);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, " rf_ack"}, {31'd0, rf_ack}, 32'd0);
        checkOutput({tag, " alu_ack"}, {31'd0, alu_ack}, 32'd0);
        checkOutput({tag, " tx_d_valid"}, {31'd0, tx_d_valid}, 32'd0);
        checkOutput({tag, " tx_p_data"}, {24'd0, tx_p_data}, 32'd0);
        checkOutput({tag, " sched_busy"}, {31'd0, sched_busy}, 32'd0);
    endtask

    task automatic applyStimulus(input int idx, input vec_t v);
        string tag;
        tag = $sformatf("row%0d", idx);
        clearLog();
        @(negedge clk);
        rf_req   = v.rf_req;
        rf_data  = v.rf_data;
        alu_req  = v.alu_req;
        alu_data = v.alu_data;
        waitAck();
        checkOutput({tag, " rf_ack"}, {31'd0, rf_ack}, {31'd0, v.exp_rf_ack});
        checkOutput({tag, " alu_ack"}, {31'd0, alu_ack}, {31'd0, v.exp_alu_ack});
        rf_req  = 1'b0;
        alu_req = 1'b0;
        @(negedge clk);
        checkOutput({tag, " ack width"}, {30'd0, rf_ack, alu_ack}, 32'd0);
        waitIdle({tag, " sched_busy clears"});
        checkOutput({tag, " byte count"}, pulse_bytes.size(), v.exp_n);
        checkOutput({tag, " byte0"}, {24'd0, pulse_bytes[0]}, {24'd0, v.exp_b0});
        if (v.exp_n > 1)
            checkOutput({tag, " byte1"}, {24'd0, pulse_bytes[1]}, {24'd0, v.exp_b1});
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{1'b1, 8'hA5, 1'b0, 16'h0000, 1'b1, 1'b0, 1, 8'hA5, 8'h00};
        vecs[1] = '{1'b0, 8'h00, 1'b1, 16'h1234, 1'b0, 1'b1, 2, 8'h34, 8'h12};
        vecs[2] = '{1'b1, 8'h5A, 1'b1, 16'hBEEF, 1'b1, 1'b0, 1, 8'h5A, 8'h00};
        vecs[3] = '{1'b1, 8'h3C, 1'b1, 16'hCAFE, 1'b0, 1'b1, 2, 8'hFE, 8'hCA};
        vecs[4] = '{1'b1, 8'h77, 1'b1, 16'h0102, 1'b1, 1'b0, 1, 8'h77, 8'h00};
        vecs[5] = '{1'b0, 8'h00, 1'b1, 16'h00FF, 1'b0, 1'b1, 2, 8'hFF, 8'h00};

        repeat (3) @(negedge clk);
        checkResetOutputs("reset");
        reset = 1'b1;
        model_en = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++) applyStimulus(i, vecs[i]);

        // Grant latency and inter-byte spacing for an ALU result.
        clearLog();
        @(negedge clk);
        alu_req  = 1'b1;
        alu_data = 16'h1234;
        @(negedge clk);
        checkOutput("timing alu_ack", {31'd0, alu_ack}, 32'd1);
        alu_req = 1'b0;
        @(negedge clk);
        checkOutput("timing ack drop", {31'd0, alu_ack}, 32'd0);
        checkOutput("timing first pulse", {31'd0, tx_d_valid}, 32'd1);
        checkOutput("timing first byte", {24'd0, tx_p_data}, 32'h34);
        @(negedge clk);
        checkOutput("timing pulse width", {31'd0, tx_d_valid}, 32'd0);
        waitIdle("timing sched_busy clears");
        checkOutput("timing byte count", pulse_bytes.size(), 2);
        checkOutput("timing second byte", {24'd0, pulse_bytes[1]}, 32'h12);
        checkOutput("timing gap after busy fall", pulse_cyc[1] - fall_cyc[0], 2);

        // Lost start: busy never rises, byte is re-issued after TIMEOUT+1 cycles.
        model_en = 1'b0;
        manual_busy = 1'b0;
        clearLog();
        @(negedge clk);
        rf_req  = 1'b1;
        rf_data = 8'h3C;
        waitAck();
        checkOutput("lost rf_ack", {31'd0, rf_ack}, 32'd1);
        rf_req = 1'b0;
        @(negedge clk);
        checkOutput("lost first pulse", {31'd0, tx_d_valid}, 32'd1);
        begin
            int n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!tx_d_valid && n < 20);
            checkOutput("lost retry gap", n, 5);
        end
        checkOutput("lost retry byte", {24'd0, tx_p_data}, 32'h3C);
        manual_busy = 1'b1;
        repeat (3) @(negedge clk);
        manual_busy = 1'b0;
        waitIdle("lost sched_busy clears");
        checkOutput("lost pulse count", pulse_bytes.size(), 2);

        // Busy already high when LOAD is entered.
        clearLog();
        manual_busy = 1'b1;
        @(negedge clk);
        rf_req  = 1'b1;
        rf_data = 8'h99;
        waitAck();
        checkOutput("entry rf_ack", {31'd0, rf_ack}, 32'd1);
        rf_req = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("entry no pulse while busy", pulse_bytes.size(), 0);
        manual_busy = 1'b0;
        @(negedge clk);
        checkOutput("entry pulse", {31'd0, tx_d_valid}, 32'd1);
        checkOutput("entry byte", {24'd0, tx_p_data}, 32'h99);
        manual_busy = 1'b1;
        repeat (2) @(negedge clk);
        manual_busy = 1'b0;
        waitIdle("entry sched_busy clears");
        checkOutput("entry pulse count", pulse_bytes.size(), 1);

        // Reset while the first ALU byte is in WAIT_LO.
        model_en = 1'b1;
        clearLog();
        @(negedge clk);
        alu_req  = 1'b1;
        alu_data = 16'h1234;
        waitAck();
        alu_req = 1'b0;
        begin
            int n = 0;
            while (!tx_d_valid && n < 20) begin
                @(negedge clk);
                n++;
            end
        end
        @(negedge clk);
        checkOutput("midreset busy before", {31'd0, sched_busy}, 32'd1);
        reset = 1'b0;
        #1;
        checkResetOutputs("midreset");
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (12) @(negedge clk);
        checkOutput("midreset no second byte", pulse_bytes.size(), 1);
        checkOutput("midreset stays idle", {31'd0, sched_busy}, 32'd0);

        // Tie after reset: RF first, held ALU next, then RF wins the repeat tie.
        clearLog();
        @(negedge clk);
        rf_req   = 1'b1;
        rf_data  = 8'h5A;
        alu_req  = 1'b1;
        alu_data = 16'h1234;
        waitAck();
        checkOutput("tie rf first", {30'd0, rf_ack, alu_ack}, 32'd2);
        rf_req = 1'b0;
        begin
            int n = 0;
            while (!alu_ack && n < 100) begin
                @(negedge clk);
                n++;
            end
        end
        checkOutput("tie alu later", {31'd0, alu_ack}, 32'd1);
        alu_req = 1'b0;
        waitIdle("tie sched_busy clears");
        checkOutput("tie byte count", pulse_bytes.size(), 3);
        checkOutput("tie bytes", {8'd0, pulse_bytes[0], pulse_bytes[1], pulse_bytes[2]}, 32'h005A3412);
        clearLog();
        @(negedge clk);
        rf_req   = 1'b1;
        rf_data  = 8'h11;
        alu_req  = 1'b1;
        alu_data = 16'h2222;
        waitAck();
        checkOutput("tie repeat rf wins", {30'd0, rf_ack, alu_ack}, 32'd2);
        rf_req  = 1'b0;
        alu_req = 1'b0;
        waitIdle("tie repeat sched_busy clears");
        checkOutput("tie repeat byte", {24'd0, pulse_bytes[0]}, 32'h11);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
